// File: rtl/vedic_mult_sequencer_if.sv
// Handshake bundle between an operand source / result consumer and vedic_mult_sequencer.
// Ports: in_valid/in_ready/a/b carry operands in, out_valid/out_ready/out carry the product out, busy flags RUN.
// master = source/consumer side, slave = sequencer side.
interface vedic_mult_sequencer_if #(
   parameter int WIDTH = 4
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     out;
   logic                   busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, out, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/vedic_mult_sequencer.sv
// Purpose: WIDTH x WIDTH unsigned multiply, one 2-bit digit pair per cycle through a shared 2x2 vedic core.
// Latency: K*K cycles from operand acceptance to out_valid (K = WIDTH/2); one result per K*K+2 cycles at best.
// Backpressure: in_ready only in IDLE; product held stable in DONE until out_ready, no path from inputs to outputs.
// Ports: clk, rst (sync, active-high); bus.slave carries in_valid/in_ready/a/b, out_valid/out_ready/out, busy.

// Combinational 2x2 vedic (urdhva tiryagbhyam) multiplier.
module vedic_multiplier_2bit (
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   output logic [3:0] p_o
);
   logic t_cross_0, t_cross_1, t_hi, c_mid;

   assign t_cross_0 = a_i[1] & b_i[0];
   assign t_cross_1 = a_i[0] & b_i[1];
   assign t_hi      = a_i[1] & b_i[1];
   assign c_mid     = t_cross_0 & t_cross_1;

   assign p_o[0] = a_i[0] & b_i[0];
   assign p_o[1] = t_cross_0 ^ t_cross_1;
   assign p_o[2] = t_hi ^ c_mid;
   assign p_o[3] = t_hi & c_mid;
endmodule

module vedic_mult_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   vedic_mult_sequencer_if.slave   bus
);
   localparam int K  = WIDTH / 2;
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        i_q, i_d;
   logic [CW-1:0]        j_q, j_d;

   // Digit selection: shifting by 2*i keeps the index arithmetic width-clean.
   logic [1:0]           a_dig, b_dig;
   logic [3:0]           pp;
   logic [CW:0]          weight;
   logic [2*WIDTH-1:0]   pp_sh;

   assign a_dig  = 2'(a_q >> {i_q, 1'b0});
   assign b_dig  = 2'(b_q >> {j_q, 1'b0});
   assign weight = {1'b0, i_q} + {1'b0, j_q};
   assign pp_sh  = (2*WIDTH)'(pp) << {weight, 1'b0};

   vedic_multiplier_2bit u_core (
      .a_i (a_dig),
      .b_i (b_dig),
      .p_o (pp)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      i_d     = i_q;
      j_d     = j_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = acc_q + pp_sh;
            if (j_q == LAST) begin
               j_d = '0;
               if (i_q == LAST) begin
                  i_d     = '0;
                  state_d = S_DONE;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         S_DONE: begin
            // Accumulator is left intact so out keeps the last product in IDLE.
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         j_q     <= j_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q == S_RUN);
   assign bus.out       = acc_q;
endmodule

// File: tb/tb_vedic_mult_sequencer.sv
// Bench for vedic_mult_sequencer at WIDTH=4 and WIDTH=8; expected products come from plain a*b.
module tb_vedic_mult_sequencer;
   logic clk;
   logic rst4, rst8;
   int   checks = 0;
   int   errors = 0;

   vedic_mult_sequencer_if #(.WIDTH(4)) if4 ();
   vedic_mult_sequencer_if #(.WIDTH(8)) if8 ();

   vedic_mult_sequencer #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4));
   vedic_mult_sequencer #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(if8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic iv, input logic ordy);
      if (!sel) begin
         if4.a = av[3:0]; if4.b = bv[3:0]; if4.in_valid = iv; if4.out_ready = ordy;
      end else begin
         if8.a = av; if8.b = bv; if8.in_valid = iv; if8.out_ready = ordy;
      end
   endtask

   task automatic sample(input bit sel, output logic ir, output logic ov,
                         output logic bz, output logic [15:0] o);
      if (!sel) begin
         ir = if4.in_ready; ov = if4.out_valid; bz = if4.busy; o = {8'd0, if4.out};
      end else begin
         ir = if8.in_ready; ov = if8.out_valid; bz = if8.busy; o = if8.out;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, count RUN cycles, optionally stall in DONE, release.
   task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv, input int hold);
      logic        ir, ov, bz;
      logic [15:0] o;
      logic [15:0] exp;
      int          lat;
      int          kk;
      kk  = sel ? 16 : 4;
      exp = 16'(av) * 16'(bv);
      sample(sel, ir, ov, bz, o);
      chk("in_ready_idle", 32'(ir), 32'd1);
      drive(sel, av, bv, 1'b1, hold == 0);
      tick();
      // Operands may change freely after acceptance.
      drive(sel, 8'($urandom), 8'($urandom), 1'b0, hold == 0);
      lat = 0;
      sample(sel, ir, ov, bz, o);
      while (!ov && lat < 64) begin
         chk("busy_run", 32'(bz), 32'd1);
         tick();
         lat++;
         sample(sel, ir, ov, bz, o);
      end
      chk("latency", 32'(lat), 32'(kk));
      chk("out_valid_done", 32'(ov), 32'd1);
      chk("product", 32'(o), 32'(exp));
      for (int h = 0; h < hold; h++) begin
         drive(sel, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
         tick();
         sample(sel, ir, ov, bz, o);
         chk("hold_out", 32'(o), 32'(exp));
         chk("hold_valid", 32'(ov), 32'd1);
         chk("hold_in_ready", 32'(ir), 32'd0);
      end
      drive(sel, 8'd0, 8'd0, 1'b0, 1'b1);
      tick();
      sample(sel, ir, ov, bz, o);
      chk("idle_in_ready", 32'(ir), 32'd1);
      chk("idle_out_valid", 32'(ov), 32'd0);
      chk("idle_busy", 32'(bz), 32'd0);
      chk("idle_out_kept", 32'(o), 32'(exp));
   endtask

   initial begin
      logic        ir, ov, bz;
      logic [15:0] o;

      rst4 = 1'b1;
      rst8 = 1'b1;
      drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      drive(1'b1, 8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      tick();
      rst4 = 1'b0;
      rst8 = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sample(s[0], ir, ov, bz, o);
         chk("rst_in_ready", 32'(ir), 32'd1);
         chk("rst_out_valid", 32'(ov), 32'd0);
         chk("rst_busy", 32'(bz), 32'd0);
         chk("rst_out", 32'(o), 32'd0);
      end

      // Directed WIDTH=4 cases.
      run_op(1'b0, 8'd3, 8'd3, 0);
      run_op(1'b0, 8'd15, 8'd15, 0);
      run_op(1'b0, 8'd0, 8'd13, 0);
      run_op(1'b0, 8'd11, 8'd6, 10);

      // Reset in the second RUN cycle discards the operation.
      drive(1'b0, 8'd9, 8'd7, 1'b1, 1'b0);
      tick();
      drive(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      sample(1'b0, ir, ov, bz, o);
      chk("midrun_busy", 32'(bz), 32'd1);
      rst4 = 1'b1;
      tick();
      rst4 = 1'b0;
      sample(1'b0, ir, ov, bz, o);
      chk("midrst_in_ready", 32'(ir), 32'd1);
      chk("midrst_out", 32'(o), 32'd0);
      chk("midrst_out_valid", 32'(ov), 32'd0);
      chk("midrst_busy", 32'(bz), 32'd0);
      run_op(1'b0, 8'd2, 8'd5, 0);

      // Exhaustive WIDTH=4 with out_ready held high.
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            run_op(1'b0, 8'(x), 8'(y), 0);

      // Directed WIDTH=8 cases.
      run_op(1'b1, 8'd255, 8'd255, 0);
      run_op(1'b1, 8'd200, 8'd3, 0);

      // Random operands and random DONE stalls on both widths.
      for (int r = 0; r < 25; r++) begin
         run_op(1'b1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
         run_op(1'b0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
